npc_predict_unit: RTL and testbench
===================================

Name: npc_predict_unit

Overview:
Sequential successor to the combinational next-PC logic. It owns the fetch PC register and predicts taken branches and jumps with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. It also resolves seq/beq/j/jr outcomes reported from decode/execute and redirects the PC with a flush on a misprediction or an exception. It sits between the instruction memory address port and the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_3000, fetch address after reset
EXC_VEC, 32'h0000_4180, exception handler entry
BTB_DEPTH, 16, BTB entries; power of two, 2..256
IDX_W, $clog2(BTB_DEPTH), index width (derived; do not override)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold PC (hazard unit)
exc_req  in  1  take exception: jump to EXC_VEC
res_valid  in  1  a control-flow instruction is being resolved this cycle
res_op  in  2  NPCOp of the resolving instr: 00 seq, 01 beq, 10 j, 11 jr
res_pc  in  32  PC of the resolving instr
res_imm  in  26  instruction immediate field
res_ra  in  32  register value for jr
res_cond  in  1  branch condition true (used only for beq)
res_pred_taken  in  1  prediction that was carried with the instr
res_pred_target  in  32  predicted target that was carried with the instr
pc  out  32  current fetch PC (registered)
pc4  out  32  pc + 4 (combinational)
pred_taken  out  1  BTB predicts taken for pc (combinational)
pred_target  out  32  predicted target for pc (valid when pred_taken)
flush  out  1  squash younger instructions this cycle (combinational)

Behaviour:
- BTB entry fields: valid, tag = pc[31:IDX_W+2], target[31:0], ctr[1:0]. Index = pc[IDX_W+1:2].
- Lookup: pred_taken = valid & tag match & ctr[1]. pred_target = entry target. Reads are read-before-write, so an update in the same cycle is seen on the next cycle.
- Actual target:
  - seq: res_pc+4.
  - beq: res_pc+4+{{14{imm[15]}},imm[15:0],2'b0}. Taken only if res_cond.
  - j: {res_pc[31:28],imm,2'b0}. Always taken.
  - jr: res_ra. Always taken.
  - All arithmetic is mod 2^32; wrap-around is silent.
- actual_taken = (op==j) | (op==jr) | (op==beq & res_cond).
- mispredict = res_valid & ((actual_taken != res_pred_taken) | (actual_taken & target != res_pred_target)).
- flush = exc_req | mispredict.
- Next-PC priority at each clk edge:
  1. reset → RESET_PC
  2. exc_req → EXC_VEC
  3. mispredict → (actual_taken ? target : res_pc+4)
  4. stall → pc unchanged
  5. pred_taken → pred_target
  6. else → pc+4
- A redirect overrides stall. A redirect with stall held loses no cycle.
- BTB update happens when res_valid & !exc_req & !reset. It is performed at the index/tag of res_pc.
  - beq hit: ctr increments if taken, decrements if not; saturates at 00/11. target is rewritten when taken.
  - beq miss: allocate only if taken, with ctr=10. Not-taken misses do not allocate.
  - j: write entry with ctr=11.
  - jr: never allocated or updated; an existing entry with a matching tag is invalidated.
  - seq: no update.
  - An allocation on a tag conflict replaces the old entry.
- Reset: pc=RESET_PC. All valid bits cleared and all ctr=01. Applies mid-operation too; resolve inputs are ignored in the reset cycle. flush and pred_taken are 0 during and immediately after reset.
- Latency: a redirect becomes visible on pc one cycle after mispredict/exc_req is asserted. The predicted target is also used for the next fetch one cycle later.

Decomposition:
- Shared package/header: NPCOp codes (SEQ/BEQ/J/JR), RESET_PC and EXC_VEC defaults, counter encodings (SNT=00, WNT=01, WT=10, ST=11).
- Sub-module npc_btb holds the storage, lookup and update logic (parametrised by BTB_DEPTH). The top holds the PC register, target computation and priority mux.

Test Plan:
1. Reset, then 3 cycles free-running → pc = 0x3000, 0x3004, 0x3008; flush=0; pred_taken=0.
2. First encounter of beq at 0x3010, imm=0x0003, res_cond=1, res_pred_taken=0 → flush=1; next pc=0x3020. Second fetch of 0x3010 → pred_taken=1, pred_target=0x3020.
3. The same beq taken twice more, then not taken with res_pred_taken=1 → ctr goes 10→11→11→10; flush=1; next pc=0x3014. The next prediction is still taken.
4. jr at 0x3040 with res_ra=0x0000_3100, res_pred_taken=0 → flush, pc=0x3100. A re-fetch of 0x3040 gives pred_taken=0 (no allocation).
5. stall=1 together with mispredict (j to 0x0000_3200), then stall=1 with no redirect → pc=0x3200 on the first edge, then held at 0x3200.
6. exc_req coincident with a mispredict and res_valid → pc=0x4180; BTB unchanged. Then reset asserted mid-run → pc=0x3000 and all predictions cleared.

Source files
------------

// File: rtl/npc_predict_unit_pkg.sv
// rtl/npc_predict_unit_pkg.sv - shared types and constants for the next-PC predictor
//
// Purpose: NPCOp codes, default reset/exception addresses, BTB counter
// encodings and the saturating-counter step helper.
package npc_predict_unit_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BEQ = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_op_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Two-bit saturating counter: move toward ST when taken, toward SNT otherwise.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != CTR_ST) begin
            nxt = ctr + 2'b01;
        end else if (!taken && ctr != CTR_SNT) begin
            nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/npc_predict_unit_btb.sv
// rtl/npc_predict_unit_btb.sv - direct-mapped branch target buffer with 2-bit counters
//
// Purpose: holds valid/tag/target/counter per entry, answers a lookup for the
// fetch PC and applies one resolve update per cycle.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   lookup_pc             fetch PC to look up
//   hit                   valid & tag match & counter predicts taken
//   hit_target            stored target of the looked-up entry
//   upd_en                apply an update this cycle
//   upd_op                NPCOp of the resolving instruction
//   upd_pc                PC of the resolving instruction (selects index/tag)
//   upd_taken             resolved direction
//   upd_target            resolved target
module npc_btb
    import npc_predict_unit_pkg::*;
#(
    parameter int BTB_DEPTH = 16,
    parameter int IDX_W     = $clog2(BTB_DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic [31:0] hit_target,
    input  logic        upd_en,
    input  logic [1:0]  upd_op,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int TAG_W = 30 - IDX_W;

    logic             entry_valid  [BTB_DEPTH];
    logic [TAG_W-1:0] entry_tag    [BTB_DEPTH];
    logic [31:0]      entry_target [BTB_DEPTH];
    logic [1:0]       entry_ctr    [BTB_DEPTH];

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_match;
    npc_op_t          u_op;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[31:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];
    assign u_op  = npc_op_t'(upd_op);

    // Lookup reads the array state before this cycle's update lands.
    assign hit        = entry_valid[l_idx] && (entry_tag[l_idx] == l_tag) && entry_ctr[l_idx][1];
    assign hit_target = entry_target[l_idx];

    assign u_match = entry_valid[u_idx] && (entry_tag[u_idx] == u_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                entry_valid[i] <= 1'b0;
                entry_ctr[i]   <= CTR_WNT;
            end
        end else if (upd_en) begin
            case (u_op)
                NPC_BEQ: begin
                    if (u_match) begin
                        entry_ctr[u_idx] <= ctr_step(entry_ctr[u_idx], upd_taken);
                        if (upd_taken) begin
                            entry_target[u_idx] <= upd_target;
                        end
                    end else if (upd_taken) begin
                        // Taken miss allocates (replacing any aliasing entry); not-taken misses never do.
                        entry_valid[u_idx]  <= 1'b1;
                        entry_tag[u_idx]    <= u_tag;
                        entry_target[u_idx] <= upd_target;
                        entry_ctr[u_idx]    <= CTR_WT;
                    end
                end
                NPC_J: begin
                    entry_valid[u_idx]  <= 1'b1;
                    entry_tag[u_idx]    <= u_tag;
                    entry_target[u_idx] <= upd_target;
                    entry_ctr[u_idx]    <= CTR_ST;
                end
                NPC_JR: begin
                    // Register-indirect targets are not worth caching; drop a stale match.
                    if (u_match) begin
                        entry_valid[u_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/npc_predict_unit.sv
// rtl/npc_predict_unit.sv - fetch PC register with BTB prediction and redirect on resolve
//
// Purpose: owns the fetch PC, predicts via npc_btb, resolves seq/beq/j/jr
// outcomes and redirects with flush on mispredict or exception.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stall                 hold the PC
//   exc_req               redirect to EXC_VEC
//   res_*                 resolving control-flow instruction and its carried prediction
//   pc, pc4               registered fetch PC and pc + 4
//   pred_taken/target     BTB prediction for pc
//   flush                 squash younger instructions this cycle
module npc_predict_unit
    import npc_predict_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
    parameter int          BTB_DEPTH = 16,
    parameter int          IDX_W     = $clog2(BTB_DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        exc_req,
    input  logic        res_valid,
    input  logic [1:0]  res_op,
    input  logic [31:0] res_pc,
    input  logic [25:0] res_imm,
    input  logic [31:0] res_ra,
    input  logic        res_cond,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_target,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        flush
);

    npc_op_t     op;
    logic [31:0] res_pc4;
    logic [31:0] beq_off;
    logic [31:0] act_target;
    logic        act_taken;
    logic        mispredict;
    logic        btb_hit;
    logic        btb_upd;

    assign op      = npc_op_t'(res_op);
    assign pc4     = pc + 32'd4;
    assign res_pc4 = res_pc + 32'd4;
    assign beq_off = {{14{res_imm[15]}}, res_imm[15:0], 2'b00};

    always_comb begin
        act_target = res_pc4;
        act_taken  = 1'b0;
        case (op)
            NPC_SEQ: begin
                act_target = res_pc4;
                act_taken  = 1'b0;
            end
            NPC_BEQ: begin
                act_target = res_pc4 + beq_off;
                act_taken  = res_cond;
            end
            NPC_J: begin
                act_target = {res_pc[31:28], res_imm, 2'b00};
                act_taken  = 1'b1;
            end
            NPC_JR: begin
                act_target = res_ra;
                act_taken  = 1'b1;
            end
            default: ;
        endcase
    end

    // A correctly predicted not-taken branch must not be penalised for a stale carried target.
    assign mispredict = res_valid &&
                        ((act_taken != res_pred_taken) ||
                         (act_taken && (act_target != res_pred_target)));

    // Outputs are forced quiet in the reset cycle since the BTB may still hold pre-reset entries.
    assign flush      = !reset && (exc_req || mispredict);
    assign pred_taken = !reset && btb_hit;

    assign btb_upd = res_valid && !exc_req && !reset;

    npc_btb #(
        .BTB_DEPTH (BTB_DEPTH),
        .IDX_W     (IDX_W)
    ) u_btb (
        .clk        (clk),
        .reset      (reset),
        .lookup_pc  (pc),
        .hit        (btb_hit),
        .hit_target (pred_target),
        .upd_en     (btb_upd),
        .upd_op     (res_op),
        .upd_pc     (res_pc),
        .upd_taken  (act_taken),
        .upd_target (act_target)
    );

    // Redirects sit above stall so a held pipeline still takes the correction without losing a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (exc_req) begin
            pc <= EXC_VEC;
        end else if (mispredict) begin
            pc <= act_taken ? act_target : res_pc4;
        end else if (!stall) begin
            pc <= pred_taken ? pred_target : pc4;
        end
    end

endmodule

// File: tb/tb_npc_predict_unit.sv
// tb/tb_npc_predict_unit.sv - scoreboard bench for npc_predict_unit
module tb_npc_predict_unit;

    localparam int          DEPTH = 16;
    localparam int          IW    = 4;
    localparam logic [31:0] RPC   = 32'h0000_3000;
    localparam logic [31:0] EVEC  = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        exc_req = 1'b0;
    logic        res_valid = 1'b0;
    logic [1:0]  res_op = 2'b00;
    logic [31:0] res_pc = 32'h0;
    logic [25:0] res_imm = 26'h0;
    logic [31:0] res_ra = 32'h0;
    logic        res_cond = 1'b0;
    logic        res_pred_taken = 1'b0;
    logic [31:0] res_pred_target = 32'h0;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        flush;

    npc_predict_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .exc_req         (exc_req),
        .res_valid       (res_valid),
        .res_op          (res_op),
        .res_pc          (res_pc),
        .res_imm         (res_imm),
        .res_ra          (res_ra),
        .res_cond        (res_cond),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .pc              (pc),
        .pc4             (pc4),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .flush           (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        pt;
        logic [31:0] ptgt;
        logic        flush;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: PC plus a table of BTB entries, counters as plain integers.
    logic [31:0] m_pc = RPC;
    bit          m_valid [DEPTH];
    int unsigned m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return int'(a >> (IW + 2));
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int i;
        i = idx_of(a);
        return m_valid[i] && (m_tag[i] == tag_of(a));
    endfunction

    task automatic step(input bit rst, input bit st, input bit ex, input bit rv,
                        input bit [1:0] op, input logic [31:0] rpc, input logic [25:0] imm,
                        input logic [31:0] ra, input bit cond, input bit pt,
                        input logic [31:0] ptgt);
        exp_t        e;
        int          li;
        int          ui;
        logic [31:0] tgt;
        bit          taken;
        bit          mis;
        @(posedge clk);
        #1;
        reset = rst; stall = st; exc_req = ex; res_valid = rv; res_op = op;
        res_pc = rpc; res_imm = imm; res_ra = ra; res_cond = cond;
        res_pred_taken = pt; res_pred_target = ptgt;

        li = idx_of(m_pc);
        case (op)
            2'd0: tgt = rpc + 32'd4;
            2'd1: tgt = rpc + 32'd4 + 32'($signed(imm[15:0])) * 32'd4;
            2'd2: tgt = (rpc & 32'hF000_0000) | (32'(imm) << 2);
            default: tgt = ra;
        endcase
        taken = (op == 2'd2) || (op == 2'd3) || (op == 2'd1 && cond);
        mis   = rv && ((taken != pt) || (taken && tgt != ptgt));

        e.pc    = m_pc;
        e.pc4   = m_pc + 32'd4;
        e.pt    = !rst && model_hit(m_pc) && m_ctr[li] >= 2;
        e.ptgt  = m_tgt[li];
        e.flush = !rst && (ex || mis);
        sb.push_back(e);

        if (rst)           m_pc = RPC;
        else if (ex)       m_pc = EVEC;
        else if (mis)      m_pc = taken ? tgt : rpc + 32'd4;
        else if (st)       m_pc = m_pc;
        else if (e.pt)     m_pc = e.ptgt;
        else               m_pc = m_pc + 32'd4;

        ui = idx_of(rpc);
        if (rst) begin
            model_reset();
        end else if (rv && !ex) begin
            if (op == 2'd1) begin
                if (model_hit(rpc)) begin
                    m_ctr[ui] = taken ? ((m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3)
                                      : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
                    if (taken) m_tgt[ui] = tgt;
                end else if (taken) begin
                    m_valid[ui] = 1'b1; m_tag[ui] = tag_of(rpc); m_tgt[ui] = tgt; m_ctr[ui] = 2;
                end
            end else if (op == 2'd2) begin
                m_valid[ui] = 1'b1; m_tag[ui] = tag_of(rpc); m_tgt[ui] = tgt; m_ctr[ui] = 3;
            end else if (op == 2'd3) begin
                if (model_hit(rpc)) m_valid[ui] = 1'b0;
            end
        end
    endtask

    task automatic idle(input bit st);
        step(1'b0, st, 1'b0, 1'b0, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Mispredicted jr used to steer fetch to a chosen address.
    task automatic goto(input logic [31:0] a);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'h0000_3070, 26'h0, a, 1'b0, 1'b0, 32'h0);
    endtask

    // Monitor: pops one expectation per cycle, away from the active edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc", pc, e.pc);
            chk("pc4", pc4, e.pc4);
            chk("pred_taken", 32'(pred_taken), 32'(e.pt));
            chk("flush", 32'(flush), 32'(e.flush));
            if (e.pt) chk("pred_target", pred_target, e.ptgt);
        end
    end

    function automatic logic [31:0] pool_pc();
        logic [31:0] a;
        a = RPC + 32'(4 * $urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) a = a + 32'(32'h40 * $urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        model_reset();
        // 1: reset then free-running
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(1'b0); idle(1'b0); idle(1'b0);
        // 2: first beq encounter, then refetch
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'h3010, 26'h0003, 32'h0, 1'b1, 1'b0, 32'h0);
        goto(32'h3010);
        idle(1'b0);
        // 3: taken twice more, then not taken while predicted taken
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'h3010, 26'h0003, 32'h0, 1'b1, 1'b1, 32'h3020);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'h3010, 26'h0003, 32'h0, 1'b1, 1'b1, 32'h3020);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'h3010, 26'h0003, 32'h0, 1'b0, 1'b1, 32'h3020);
        idle(1'b0);
        goto(32'h3010);
        idle(1'b0);
        // 4: jr does not allocate
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'h3040, 26'h0, 32'h3100, 1'b0, 1'b0, 32'h0);
        goto(32'h3040);
        idle(1'b0);
        // 5: redirect under stall, then held
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 32'h3050, 26'h0C80, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(1'b1); idle(1'b1); idle(1'b0);
        // 6: exception beats mispredict, then mid-run reset
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h3018, 26'h0010, 32'h0, 1'b1, 1'b0, 32'h0);
        goto(32'h3010);
        idle(1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h3054, 26'h0C80, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(1'b0);
        goto(32'h3010);
        idle(1'b0);
        // Random phase
        for (int n = 0; n < 400; n++) begin
            bit          rst, st, ex, rv, cond, pt;
            bit [1:0]    op;
            logic [31:0] rpc, ra, ptgt;
            logic [25:0] imm;
            rst  = ($urandom_range(0, 99) < 2);
            st   = ($urandom_range(0, 3) == 0);
            ex   = ($urandom_range(0, 99) < 5);
            rv   = ($urandom_range(0, 1) == 1);
            op   = 2'($urandom_range(0, 3));
            rpc  = pool_pc();
            ra   = ($urandom_range(0, 3) != 0) ? pool_pc() : $urandom;
            cond = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 2))
                0: imm = 26'($urandom_range(0, 15));
                1: imm = 26'(pool_pc() >> 2);
                default: imm = 26'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) begin
                pt   = model_hit(rpc) && m_ctr[idx_of(rpc)] >= 2;
                ptgt = m_tgt[idx_of(rpc)];
            end else begin
                pt   = 1'($urandom_range(0, 1));
                ptgt = pool_pc();
            end
            step(rst, st, ex, rv, op, rpc, imm, ra, cond, pt, ptgt);
        end
        idle(1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
